alarm_ring_ctrl: RTL and testbench

// - Sequences the alarm for the 12-hour clock. It compares the running clock time against the

---
 rtl/alarm_ring_ctrl_pkg.sv | 19 +
 rtl/alarm_ring_ctrl_if.sv | 27 ++
 rtl/alarm_ring_ctrl_tone_gen.sv | 42 ++++
 rtl/alarm_ring_ctrl.sv | 108 ++++++++++
 tb/tb_alarm_ring_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/alarm_ring_ctrl_pkg.sv
// alarm_pkg: shared state encoding, BCD time type and comparison helper for the alarm controller
package alarm_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_RINGING  = 2'b10,
    ST_SNOOZE   = 2'b11
  } state_t;
  typedef struct packed {
    logic [BCD_W-1:0] hourten;
    logic [BCD_W-1:0] hour;
    logic [BCD_W-1:0] minten;
    logic [BCD_W-1:0] min;
  } bcd_time_t;
  function automatic logic bcd_time_eq(input bcd_time_t a, input bcd_time_t b);
    return a == b;
  endfunction
endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// alarm_ring_ctrl_if: time, button and board I/O bundle between the alarm controller and its neighbours
interface alarm_ring_ctrl_if;
  import alarm_pkg::*;
  logic             sec_tick;
  logic [BCD_W-1:0] cur_hourten, cur_hour, cur_minten, cur_min;
  logic [BCD_W-1:0] alarm_hourten, alarm_hour, alarm_minten, alarm_min;
  logic             alarm_edit;
  logic             alarm_en;
  logic             snooze_p;
  logic             dismiss_p;
  logic             buzzer;
  logic             ring_led;
  logic             snooze_led;
  logic [1:0]       state;
  modport master (
    output sec_tick, cur_hourten, cur_hour, cur_minten, cur_min,
           alarm_hourten, alarm_hour, alarm_minten, alarm_min,
           alarm_edit, alarm_en, snooze_p, dismiss_p,
    input  buzzer, ring_led, snooze_led, state
  );
  modport slave (
    input  sec_tick, cur_hourten, cur_hour, cur_minten, cur_min,
           alarm_hourten, alarm_hour, alarm_minten, alarm_min,
           alarm_edit, alarm_en, snooze_p, dismiss_p,
    output buzzer, ring_led, snooze_led, state
  );
endinterface

// File: rtl/alarm_ring_ctrl_tone_gen.sv
// tone_gen: buzzer tone divider gated by a 0.5 s on / 0.5 s off cadence divider
module tone_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TONE_HZ = 2_000
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic out
);
  localparam int TH = CLK_HZ / (2 * TONE_HZ);
  localparam int CH = CLK_HZ / 2;
  localparam int TW = $clog2(TH + 1);
  localparam int CW = $clog2(CH + 1);
  logic [TW-1:0] tone_cnt;
  logic [CW-1:0] cad_cnt;
  logic          tone, cad;
  logic          tone_wrap, cad_wrap;
  assign tone_wrap = tone_cnt == TW'(TH - 1);
  assign cad_wrap  = cad_cnt == CW'(CH - 1);
  assign out       = tone & cad;
  // restart starts both phases high so the first burst of a ring is full length
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      cad_cnt  <= '0;
      tone     <= 1'b0;
      cad      <= 1'b0;
    end else if (restart) begin
      tone_cnt <= '0;
      cad_cnt  <= '0;
      tone     <= 1'b1;
      cad      <= 1'b1;
    end else if (en) begin
      tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
      cad_cnt  <= cad_wrap ? '0 : cad_cnt + 1'b1;
      tone     <= tone ^ tone_wrap;
      cad      <= cad ^ cad_wrap;
    end
  end
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm FSM with minute-entry trigger, snooze, dismiss, ring timeout and buzzer gating
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TONE_HZ        = 2_000,
  parameter int SNOOZE_S       = 540,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_AUTO       = 3
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  alarm_ring_ctrl_if.slave bus
);
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam int AW = $clog2(MAX_AUTO + 1);
  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt, ring_d;
  logic [SW-1:0] snz_cnt, snz_d;
  logic [AW-1:0] auto_cnt, auto_d;
  bcd_time_t     cur_t, alarm_t;
  logic          match, match_q, trig, tone_out, buzzer_q;
  assign cur_t          = {bus.cur_hourten, bus.cur_hour, bus.cur_minten, bus.cur_min};
  assign alarm_t        = {bus.alarm_hourten, bus.alarm_hour, bus.alarm_minten, bus.alarm_min};
  assign match          = bcd_time_eq(cur_t, alarm_t);
  assign trig           = match & ~match_q & ~bus.alarm_edit;
  assign bus.state      = state_q;
  assign bus.ring_led   = state_q == ST_RINGING;
  assign bus.snooze_led = state_q == ST_SNOOZE;
  assign bus.buzzer     = buzzer_q;
  // match_q powers up high so releasing reset on the alarm minute cannot ring
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q  <= ST_DISARMED;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      auto_cnt <= '0;
      match_q  <= 1'b1;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ring_cnt <= ring_d;
      snz_cnt  <= snz_d;
      auto_cnt <= auto_d;
      match_q  <= match;
      buzzer_q <= tone_out & (state_q == ST_RINGING) & (state_d == ST_RINGING);
    end
  end
  // next state and counters; buttons are tested before the timeout tick so they win
  always_comb begin
    state_d = state_q;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    auto_d  = auto_cnt;
    if (!bus.alarm_en) begin
      state_d = ST_DISARMED;
      ring_d  = '0;
      snz_d   = '0;
      auto_d  = '0;
    end else begin
      case (state_q)
        ST_DISARMED: state_d = ST_ARMED;
        ST_ARMED: if (trig) begin
          state_d = ST_RINGING;
          ring_d  = '0;
          auto_d  = '0;
        end
        ST_RINGING: if (bus.dismiss_p) begin
          state_d = ST_ARMED;
        end else if (bus.snooze_p) begin
          state_d = ST_SNOOZE;
          snz_d   = SW'(SNOOZE_S);
        end else if (bus.sec_tick) begin
          if (ring_cnt == RW'(RING_TIMEOUT_S - 1)) begin
            if (auto_cnt == AW'(MAX_AUTO - 1)) begin
              state_d = ST_ARMED;
            end else begin
              state_d = ST_SNOOZE;
              auto_d  = auto_cnt + 1'b1;
              snz_d   = SW'(SNOOZE_S);
            end
          end else begin
            ring_d = ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: if (bus.dismiss_p) begin
          state_d = ST_ARMED;
        end else if (bus.sec_tick) begin
          if (snz_cnt == SW'(1)) begin
            state_d = ST_RINGING;
            ring_d  = '0;
          end else if (snz_cnt != '0) begin
            snz_d = snz_cnt - 1'b1;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end
  tone_gen #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ)) u_tone (
    .CLK100MHZ(CLK100MHZ),
    .reset    (reset),
    .en       (state_q == ST_RINGING),
    .restart  ((state_d == ST_RINGING) && (state_q != ST_RINGING)),
    .out      (tone_out)
  );
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed checks of triggering, snooze, timeout, edit masking, disarm and reset
module tb_alarm_ring_ctrl;
  logic CLK100MHZ = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  alarm_ring_ctrl_if bus ();
  alarm_ring_ctrl #(
    .CLK_HZ(1000), .TONE_HZ(100), .SNOOZE_S(3), .RING_TIMEOUT_S(4), .MAX_AUTO(2)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset    (reset),
    .bus      (bus)
  );
  always #5 CLK100MHZ = ~CLK100MHZ;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask
  task automatic sec(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_tick = 1'b1;
      tick();
      bus.sec_tick = 1'b0;
      tick();
    end
  endtask
  task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    bus.cur_hourten = a;
    bus.cur_hour    = b;
    bus.cur_minten  = c;
    bus.cur_min     = d;
  endtask
  task automatic set_alarm(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    bus.alarm_hourten = a;
    bus.alarm_hour    = b;
    bus.alarm_minten  = c;
    bus.alarm_min     = d;
  endtask
  task automatic press(input logic snz, input logic dis);
    bus.snooze_p  = snz;
    bus.dismiss_p = dis;
    tick();
    bus.snooze_p  = 1'b0;
    bus.dismiss_p = 1'b0;
  endtask
  initial begin
    reset          = 1'b1;
    bus.sec_tick   = 1'b0;
    bus.alarm_edit = 1'b0;
    bus.alarm_en   = 1'b0;
    bus.snooze_p   = 1'b0;
    bus.dismiss_p  = 1'b0;
    set_cur(4'd0, 4'd7, 4'd2, 4'd9);
    set_alarm(4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_buzzer", 32'(bus.buzzer), 32'd0);
    chk("rst_ring_led", 32'(bus.ring_led), 32'd0);
    chk("rst_snooze_led", 32'(bus.snooze_led), 32'd0);
    reset = 1'b0;
    tick();
    chk("disarmed_idle", 32'(bus.state), 32'd0);
    bus.alarm_en = 1'b1;
    tick();
    chk("armed", 32'(bus.state), 32'd1);
    set_cur(4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    chk("s1_ringing", 32'(bus.state), 32'd2);
    chk("s1_ring_led", 32'(bus.ring_led), 32'd1);
    chk("s1_buzzer_lag", 32'(bus.buzzer), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("s1_buzzer_%0d", i), 32'(bus.buzzer), (((i - 1) / 5) % 2 == 0) ? 32'd1 : 32'd0);
    end
    press(1'b1, 1'b0);
    chk("s2_snooze", 32'(bus.state), 32'd3);
    chk("s2_snooze_led", 32'(bus.snooze_led), 32'd1);
    chk("s2_ring_led_off", 32'(bus.ring_led), 32'd0);
    chk("s2_buzzer_off", 32'(bus.buzzer), 32'd0);
    sec(2);
    chk("s2_snooze_2ticks", 32'(bus.state), 32'd3);
    sec(1);
    chk("s2_rering", 32'(bus.state), 32'd2);
    tick();
    press(1'b0, 1'b1);
    chk("s2_dismiss", 32'(bus.state), 32'd1);
    tick();
    chk("s2_dismiss_buzzer", 32'(bus.buzzer), 32'd0);
    set_cur(4'd0, 4'd7, 4'd3, 4'd1);
    tick();
    set_cur(4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    chk("s3_ringing", 32'(bus.state), 32'd2);
    sec(3);
    chk("s3_ring_3ticks", 32'(bus.state), 32'd2);
    sec(1);
    chk("s3_auto_snooze", 32'(bus.state), 32'd3);
    sec(3);
    chk("s3_auto_rering", 32'(bus.state), 32'd2);
    sec(3);
    chk("s3_ring2_3ticks", 32'(bus.state), 32'd2);
    sec(1);
    chk("s3_give_up", 32'(bus.state), 32'd1);
    bus.alarm_edit = 1'b1;
    set_cur(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    set_alarm(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    tick();
    chk("s4_edit_no_ring", 32'(bus.state), 32'd1);
    bus.alarm_edit = 1'b0;
    tick();
    tick();
    chk("s4_release_no_ring", 32'(bus.state), 32'd1);
    set_cur(4'd1, 4'd2, 4'd0, 4'd1);
    tick();
    set_cur(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    chk("s4_next_match_rings", 32'(bus.state), 32'd2);
    tick();
    tick();
    bus.alarm_en = 1'b0;
    tick();
    chk("s5_disarm", 32'(bus.state), 32'd0);
    chk("s5_buzzer", 32'(bus.buzzer), 32'd0);
    chk("s5_ring_led", 32'(bus.ring_led), 32'd0);
    bus.alarm_en = 1'b1;
    tick();
    tick();
    tick();
    chk("s5_rearm_no_ring", 32'(bus.state), 32'd1);
    set_cur(4'd1, 4'd2, 4'd0, 4'd1);
    tick();
    set_cur(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    press(1'b1, 1'b0);
    chk("s6_snooze", 32'(bus.state), 32'd3);
    reset = 1'b1;
    #1;
    chk("s6_async_state", 32'(bus.state), 32'd0);
    chk("s6_async_snooze_led", 32'(bus.snooze_led), 32'd0);
    chk("s6_async_buzzer", 32'(bus.buzzer), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    tick();
    chk("s6_post_reset_no_ring", 32'(bus.state), 32'd1);
    set_cur(4'd1, 4'd2, 4'd0, 4'd1);
    tick();
    set_cur(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    chk("s6_ringing", 32'(bus.state), 32'd2);
    press(1'b1, 1'b1);
    chk("s6_dismiss_wins", 32'(bus.state), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
